uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  Configurable UART transmitter. It is the transmit-side counterpart of the block's frame receiver.
//  It accepts one data word over a valid/ready handshake and serialises it on tx, LSB first, as:
//    start bit, 5..8 data bits, optional even/odd parity bit, 1 or 2 stop bits.
//  Frame format comes from the config register block. It is sampled once, at frame start.
// PARAMETERS
//  BASE_CLKS_PER_BIT  32  clk cycles per bit at the fastest rate (9600 baud, 100 MHz clk, scaled)
//  DIV_W              12  width of the internal bit-period counter; must hold BASE_CLKS_PER_BIT<<3
// PORTS
//  clk         in   1  system clock; all state updates on its rising edge
//  rst         in   1  asynchronous, active-low reset
//  tx_data     in   8  word to send; only the low frame_len bits are transmitted
//  tx_valid    in   1  tx_data is valid
//  tx_ready    out  1  high when a word can be accepted (IDLE only)
//  baud_sel    in   2  bit period = BASE_CLKS_PER_BIT << baud_sel (0=9600, 1=4800, 2=2400, 3=1200)
//  parity_en   in   1  1 = append a parity bit
//  parity_odd  in   1  0 = even parity, 1 = odd parity (ignored when parity_en=0)
//  stop2       in   1  0 = one stop bit, 1 = two stop bits
//  frame_len   in   4  data bits per frame, 5..8; values <5 act as 5, values >8 act as 8
//  tx          out  1  serial line; idles high
//  busy        out  1  high from acceptance until the last stop bit ends
//  tx_done     out  1  one-cycle pulse in the cycle after the last stop bit ends
// BEHAVIOUR
//  Reset (rst=0, asynchronous): tx=1, tx_ready=0, busy=0, tx_done=0, state=IDLE, counters=0.
//    tx_ready rises in the first clk edge after rst is released.
//  Handshake: a word is accepted on an edge where tx_valid & tx_ready.
//    At that edge: capture tx_data and all config inputs; tx_ready<=0; busy<=1; enter START.
//    Config changes after acceptance have no effect on the current frame.
//  tx is registered. It goes 0 on the edge of acceptance, so the start bit is visible in the next cycle.
//  Each bit holds tx for exactly P = BASE_CLKS_PER_BIT<<baud_sel_latched cycles.
//  FSM:
//    IDLE   -> START on acceptance
//    START  (tx=0, P cycles)            -> DATA
//    DATA   (bit k = data[k], k=0..N-1) -> PARITY if parity_en, else STOP
//    PARITY (even: ^data[N-1:0]; odd: ~^data[N-1:0]) -> STOP
//    STOP   (tx=1, P or 2P cycles)      -> IDLE
//  N = clamped frame_len. Bits above N-1 are not sent and do not enter the parity calculation.
//  Frame length in cycles = P*(1 + N + parity_en + 1 + stop2).
//  On the edge that ends STOP: state=IDLE, busy<=0, tx_ready<=1, tx_done<=1 for one cycle.
//  Back-to-back frames: if tx_valid is held high, the next word is accepted on the first edge that
//    tx_ready is high. The line therefore idles high for exactly 1 cycle between frames.
//  tx_valid while busy is ignored: the word is not captured and the sender must hold it.
//  Reset mid-frame: the frame is aborted and tx=1 immediately. No tx_done is produced.
// TESTING
//  1. Default format (baud_sel=0, par even, stop2=0, len=8), send 8'h3A
//     -> tx: 0, 0,1,0,1,1,1,0,0, parity 0, stop 1; each bit 32 cycles;
//        tx_done 352 cycles after acceptance.
//  2. baud_sel=1, send 8'h3A -> same bit pattern, 64 cycles/bit; tx_done after 704 cycles.
//  3. frame_len=6, send 8'hFA -> data 0,1,0,1,1,1, parity 0, stop; 9 bits, 288 cycles.
//     Repeat with frame_len=3 and with frame_len=12 -> same as len 5 and len 8 respectively.
//  4. parity_en=0, send 8'h3A -> 10 bits (320 cycles), no parity bit.
//     parity_odd=1, send 8'h3A -> parity bit 1.
//  5. stop2=1, send 8'h3A -> two 32-cycle stop bits, 384 cycles.
//     Change baud_sel and stop2 mid-frame -> current frame unaffected.
//  6. tx_valid held high with two words -> second start bit 1 cycle after the first tx_done.
//     Assert rst during DATA bit 3 -> tx=1 and busy=0 at once; no tx_done.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, 5..8 data bits LSB first, optional even/odd parity, 1 or 2 stop bits.
// Frame format and bit rate are latched when a word is accepted over the valid/ready handshake.
module uart_tx_frame #(
    parameter int unsigned BASE_CLKS_PER_BIT = 32,
    parameter int unsigned DIV_W             = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic [1:0] baud_sel,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       stop2,
    input  logic [3:0] frame_len,
    output logic       tx,
    output logic       busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state;
    state_t           state_next;
    logic [DIV_W-1:0] clk_cnt;
    logic [DIV_W-1:0] period;
    logic [7:0]       data_l;
    logic [3:0]       len_l;
    logic             par_en_l;
    logic             par_odd_l;
    logic             stop2_l;
    logic [2:0]       bit_idx;
    logic [2:0]       idx_next;
    logic             stop_idx;
    logic             accept;
    logic             bit_end;
    logic             last_data;
    logic             parity_bit;
    logic             tx_d;
    logic [3:0]       len_clamped;
    logic [7:0]       data_mask;

    assign accept     = tx_valid & tx_ready;
    assign bit_end    = (state != IDLE) && (clk_cnt == period - DIV_W'(1));
    assign last_data  = ({1'b0, bit_idx} == len_l - 4'd1);
    assign data_mask  = 8'hFF >> (4'd8 - len_l);
    assign parity_bit = (^(data_l & data_mask)) ^ par_odd_l;

    always_comb begin
        len_clamped = frame_len;
        if (frame_len < 4'd5)
            len_clamped = 4'd5;
        else if (frame_len > 4'd8)
            len_clamped = 4'd8;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (bit_end) state_next = DATA;
            DATA:    if (bit_end && last_data) state_next = par_en_l ? PARITY : STOP;
            PARITY:  if (bit_end) state_next = STOP;
            STOP:    if (bit_end && (stop_idx == stop2_l)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // tx is registered, so the value is chosen from the state being entered on this edge.
    always_comb begin
        idx_next = (state == DATA && bit_end) ? bit_idx + 3'd1 : bit_idx;
        tx_d     = 1'b1;
        case (state_next)
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_l[idx_next];
            PARITY:  tx_d = parity_bit;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx        <= 1'b1;
            tx_ready  <= 1'b0;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            clk_cnt   <= '0;
            period    <= '0;
            data_l    <= '0;
            len_l     <= '0;
            par_en_l  <= 1'b0;
            par_odd_l <= 1'b0;
            stop2_l   <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
        end else begin
            tx       <= tx_d;
            tx_ready <= (state_next == IDLE);
            busy     <= (state_next != IDLE);
            tx_done  <= (state == STOP) && (state_next == IDLE);
            if (accept) begin
                data_l    <= tx_data;
                len_l     <= len_clamped;
                par_en_l  <= parity_en;
                par_odd_l <= parity_odd;
                stop2_l   <= stop2;
                period    <= DIV_W'(BASE_CLKS_PER_BIT) << baud_sel;
                clk_cnt   <= '0;
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
            end else if (state != IDLE) begin
                if (bit_end) begin
                    clk_cnt <= '0;
                    if (state == DATA) bit_idx <= bit_idx + 3'd1;
                    if (state == STOP) stop_idx <= 1'b1;
                end else begin
                    clk_cnt <= clk_cnt + DIV_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: each frame is compared cycle by cycle against a
// bit list built from the frame-format rules (start, N data bits, parity, stop bits).
module tb_uart_tx_frame;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [1:0] baud_sel;
    logic       parity_en;
    logic       parity_odd;
    logic       stop2;
    logic [3:0] frame_len;
    logic       tx;
    logic       busy;
    logic       tx_done;

    int asserts = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    uart_tx_frame #(.BASE_CLKS_PER_BIT(32), .DIV_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .baud_sel  (baud_sel),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .stop2     (stop2),
        .frame_len (frame_len),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    // Sends one frame and checks every cycle of it. pre_acc: word was already accepted on the
    // coming edge (back-to-back). hold: keep tx_valid high with nd as the next word.
    // midchange: disturb config and data mid-frame. poke: pulse tx_valid while busy.
    task automatic run_frame(input logic [7:0] d, input logic [1:0] b, input logic pe,
                             input logic po, input logic s2, input logic [3:0] fl,
                             input bit pre_acc, input bit hold, input logic [7:0] nd,
                             input bit midchange, input bit poke, input string name);
        bit bits[$];
        int n, p, ones, f, busy_bad, done_bad;
        int good[16];
        bit ready_seen;
        n = (fl < 5) ? 5 : ((fl > 8) ? 8 : int'(fl));
        p = 32 << b;
        ones = 0;
        bits.push_back(1'b0);
        for (int k = 0; k < n; k++) begin
            bits.push_back(d[k]);
            ones += int'(d[k]);
        end
        if (pe) bits.push_back(po ? (ones % 2 == 0) : (ones % 2 == 1));
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        f = p * bits.size();
        for (int i = 0; i < 16; i++) good[i] = 0;
        busy_bad = 0;
        done_bad = 0;

        if (!pre_acc) begin
            ready_seen = 0;
            for (int w = 0; w < 200 && !ready_seen; w++) begin
                @(negedge clk);
                if (tx_ready === 1'b1) ready_seen = 1;
            end
            asserts++;
            if (!ready_seen) begin
                errors++;
                $display("FAIL %s ready_timeout: tx_ready=%b, required 1 within 200 cycles", name, tx_ready);
                return;
            end
            tx_data    = d;
            baud_sel   = b;
            parity_en  = pe;
            parity_odd = po;
            stop2      = s2;
            frame_len  = fl;
            tx_valid   = 1'b1;
        end
        @(posedge clk);
        #1;
        asserts++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s accept_ready: tx_ready=%b, required 0", name, tx_ready);
        end

        for (int c = 0; c < f; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (tx === bits[c / p]) good[c / p]++;
            if (busy !== 1'b1) busy_bad++;
            if (tx_done !== 1'b0) done_bad++;
            if (c == 0) begin
                if (hold) tx_data = nd;
                else tx_valid = 1'b0;
            end
            if (midchange && c == 3 * p) begin
                baud_sel  = ~b;
                stop2     = ~s2;
                parity_en = ~pe;
                frame_len = 4'd5;
                tx_data   = ~d;
            end
            if (poke && c == p + 5) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
            end
            if (poke && c == p + 9) tx_valid = 1'b0;
        end

        for (int i = 0; i < bits.size(); i++) begin
            asserts++;
            if (good[i] !== p) begin
                errors++;
                $display("FAIL %s bit%0d: %0d of %0d cycles had tx=%b", name, i, good[i], p, bits[i]);
            end
        end
        asserts++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL %s busy_in_frame: %0d cycles busy low, required 0", name, busy_bad);
        end
        asserts++;
        if (done_bad !== 0) begin
            errors++;
            $display("FAIL %s early_done: %0d cycles tx_done high, required 0", name, done_bad);
        end

        @(posedge clk);
        #1;
        asserts++;
        if ({tx_done, busy, tx_ready, tx} !== 4'b1011) begin
            errors++;
            $display("FAIL %s frame_end(cycle %0d): done/busy/ready/tx=%b, required 1011", name, f,
                     {tx_done, busy, tx_ready, tx});
        end
        if (!hold) begin
            @(posedge clk);
            #1;
            asserts++;
            if (tx_done !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse_width: tx_done=%b, required 0", name, tx_done);
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        baud_sel   = '0;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        frame_len  = 4'd8;
        repeat (3) @(posedge clk);
        #1;
        asserts++;
        if ({tx, tx_ready, busy, tx_done} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state: tx/ready/busy/done=%b, required 1000", {tx, tx_ready, busy, tx_done});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        asserts++;
        if (tx_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: tx_ready=%b, required 0 before first edge", tx_ready);
        end
        @(posedge clk);
        #1;
        asserts++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge_ready: tx_ready=%b, required 1", tx_ready);
        end
    endtask

    task automatic test_default();
        run_frame(8'h3A, 2'd0, 1'b1, 1'b0, 1'b0, 4'd8, 0, 0, 8'h00, 0, 0, "default_3A");
    endtask

    task automatic test_baud();
        run_frame(8'h3A, 2'd1, 1'b1, 1'b0, 1'b0, 4'd8, 0, 0, 8'h00, 0, 0, "baud1_3A");
    endtask

    task automatic test_frame_len();
        run_frame(8'hFA, 2'd0, 1'b1, 1'b0, 1'b0, 4'd6, 0, 0, 8'h00, 0, 0, "len6_FA");
        run_frame(8'hFA, 2'd0, 1'b1, 1'b0, 1'b0, 4'd3, 0, 0, 8'h00, 0, 0, "len3_FA");
        run_frame(8'hFA, 2'd0, 1'b1, 1'b0, 1'b0, 4'd12, 0, 0, 8'h00, 0, 0, "len12_FA");
    endtask

    task automatic test_parity();
        run_frame(8'h3A, 2'd0, 1'b0, 1'b0, 1'b0, 4'd8, 0, 0, 8'h00, 0, 0, "no_parity_3A");
        run_frame(8'h3A, 2'd0, 1'b1, 1'b1, 1'b0, 4'd8, 0, 0, 8'h00, 0, 0, "odd_parity_3A");
    endtask

    task automatic test_stop2();
        run_frame(8'h3A, 2'd0, 1'b1, 1'b0, 1'b1, 4'd8, 0, 0, 8'h00, 0, 0, "stop2_3A");
        run_frame(8'hC5, 2'd0, 1'b1, 1'b0, 1'b0, 4'd8, 0, 0, 8'h00, 1, 0, "midframe_cfg_change");
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0, w1;
        w0 = 8'($urandom);
        w1 = 8'($urandom);
        run_frame(w0, 2'd0, 1'b1, 1'b1, 1'b0, 4'd7, 0, 1, w1, 0, 0, "b2b_first");
        run_frame(w1, 2'd0, 1'b1, 1'b1, 1'b0, 4'd7, 1, 0, 8'h00, 0, 0, "b2b_second");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_frame(8'($urandom), 2'($urandom_range(0, 1)), 1'($urandom), 1'($urandom), 1'($urandom),
                      4'($urandom_range(0, 15)), 0, 0, 8'h00, 0, 1, $sformatf("random%0d", i));
        end
    endtask

    task automatic test_reset_midframe();
        int done_seen, tx_low;
        bit ready_seen;
        ready_seen = 0;
        for (int w = 0; w < 200 && !ready_seen; w++) begin
            @(negedge clk);
            if (tx_ready === 1'b1) ready_seen = 1;
        end
        tx_data    = 8'hFF;
        baud_sel   = 2'd0;
        parity_en  = 1'b1;
        parity_odd = 1'b0;
        stop2      = 1'b0;
        frame_len  = 4'd8;
        tx_valid   = 1'b1;
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        repeat (32 * 4 + 10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        asserts++;
        if ({tx, busy, tx_done} !== 3'b100) begin
            errors++;
            $display("FAIL reset_midframe: tx/busy/done=%b, required 100", {tx, busy, tx_done});
        end
        @(negedge clk);
        rst = 1'b1;
        done_seen = 0;
        tx_low    = 0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (tx_done !== 1'b0) done_seen++;
            if (tx !== 1'b1) tx_low++;
        end
        asserts++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL reset_no_done: %0d cycles tx_done high, required 0", done_seen);
        end
        asserts++;
        if (tx_low !== 0) begin
            errors++;
            $display("FAIL reset_line_idle: %0d cycles tx low, required 0", tx_low);
        end
    endtask

    initial begin
        test_reset();
        test_default();
        test_baud();
        test_frame_len();
        test_parity();
        test_stop2();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
        $finish;
    end

endmodule
